tsmp_egress_arb: RTL and testbench
==================================

Name: tsmp_egress_arb

Overview:
Merges TSMP response/report frames from the HCP and PLC engines onto the single 9-bit egress byte stream toward the MAC.
- Each source pushes whole frames with no backpressure. Each source has its own frame FIFO.
- A frame-level round-robin scheduler drains only complete, committed frames.
- Frames are never interleaved on the output.
- A frame that does not fit in its FIFO is dropped whole, and a drop pulse is raised.

Parameters:
DATA_WIDTH, 9, byte width; bit DATA_WIDTH-1 is the frame delimiter flag, 1 on the first and last byte of a frame.
FIFO_AW, 8, per-source FIFO address width; depth = 2**FIFO_AW bytes.
IFG, 2, idle cycles forced on the output between consecutive frames; 0 is legal (back-to-back frames).

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous, active-low reset
iv_data_hcp  in  DATA_WIDTH  HCP frame byte
i_data_wr_hcp  in  1  HCP byte valid
iv_data_plc  in  DATA_WIDTH  PLC frame byte
i_data_wr_plc  in  1  PLC byte valid
ov_data  out  DATA_WIDTH  egress byte; 0 when o_data_wr=0
o_data_wr  out  1  egress byte valid
o_drop_hcp  out  1  one-cycle pulse, HCP frame dropped
o_drop_plc  out  1  one-cycle pulse, PLC frame dropped
ov_grant  out  2  one-hot source currently being sent ([0]=HCP, [1]=PLC); 0 when idle

Behaviour:
- Reset: all outputs 0; FIFOs empty; committed-frame counters 0; RR pointer favours HCP; all FSMs in IDLE. Reset mid-frame discards all partial and stored frames.
- Ingest FSM, one per source; only cycles with wr=1 are considered:
  - IDLE: byte with flag=1 is written as the head and saves frame_start=wr_ptr; go BODY. Bytes with flag=0 are ignored as stray.
  - BODY: byte written. If flag=1 it is the tail: commit by incrementing frame_cnt, go IDLE. A frame is at least 2 bytes.
  - Overflow: a write attempted with occupancy == depth, including on the head or tail byte. Effects:
    - wr_ptr restored to frame_start;
    - o_drop_x pulses the next cycle;
    - if the overflowing byte was the tail, go IDLE; otherwise go DISCARD.
  - DISCARD: write nothing; a flag=1 byte ends the frame and returns to IDLE.
  - Frames longer than depth are therefore always dropped.
  - Committed data is never corrupted by an in-progress or dropped frame.
- FIFO: show-ahead (head word visible combinationally). Occupancy is counted up to depth inclusive (FIFO_AW+1-bit pointers). Pointers wrap naturally.
- Scheduler FSM:
  - IDLE: eligible = frame_cnt>0.
    - One source eligible: grant it.
    - Both eligible: grant the one not granted last.
    - Grant updates ov_grant and goes SEND.
  - SEND: every cycle, pop the head word into the ov_data register with o_data_wr=1.
    - The popped word with flag=1 that is not the first byte is the tail. On the tail pop, decrement that source's frame_cnt, update the RR pointer, and go GAP (or IDLE if IFG=0).
  - GAP: count IFG cycles with o_data_wr=0, then go IDLE.
- Latency: a tail committed in cycle N makes the source eligible in N+1; its first byte is on ov_data in N+3 at the earliest. Output is contiguous for the frame length.
- Simultaneous commit and decrement on the same counter in one cycle: net 0, and must be handled explicitly.
- Ingest continues while the same FIFO is being drained; reading frees space in the same cycle for occupancy purposes only on the following cycle (conservative full).

Decomposition:
- Package tsmp_pkg holds the shared definitions:
  - DATA_WIDTH;
  - the delimiter bit index;
  - ingest states (IDLE/BODY/DISCARD) and scheduler states (IDLE/SEND/GAP);
  - source indices SRC_HCP=0, SRC_PLC=1.
- Sub-module tsmp_frame_fifo contains the FIFO, the ingest FSM, the frame_cnt counter and the drop pulse. It is instantiated twice.
- The top level holds the scheduler and the output register.

Test Plan:
- HCP 4-byte frame 0x1AA,0x011,0x022,0x1BB, PLC idle -> output exactly those 4 bytes contiguous, first byte 3 cycles after the tail write; ov_grant=01 during send.
- HCP and PLC both commit 3-byte frames in the same cycle, then both commit again -> order HCP,PLC,HCP,PLC with exactly IFG=2 idle cycles between frames.
- FIFO_AW=3, HCP frame of 10 bytes -> o_drop_hcp pulses once, no output; a following 5-byte HCP frame is output intact.
- Stray bytes 0x055,0x066 with flag=0 before a head -> ignored; a subsequent valid frame is output unchanged.
- PLC frame is being drained while the next PLC frame commits on the same cycle as the tail pop -> frame_cnt stays 1, and the second frame is sent after the IFG.
- Assert i_rst_n low mid-SEND -> o_data_wr=0, ov_data=0 and ov_grant=0 immediately; no residual bytes after reset release.

Source files
------------

// File: rtl/tsmp_pkg.sv
// Shared definitions for the TSMP egress arbiter.
//   DATA_WIDTH  : egress byte width (8 data bits + frame delimiter flag)
//   FLAG_BIT    : index of the delimiter flag (1 on first and last byte)
//   ing_state_t : per-source ingest FSM states
//   sch_state_t : frame scheduler states
//   SRC_HCP/SRC_PLC : source indices used for grant vectors and arrays
//   rr_pick()   : one-hot round-robin choice between the two sources
package tsmp_pkg;

    localparam int DATA_WIDTH = 9;
    localparam int FLAG_BIT   = DATA_WIDTH - 1;

    localparam int SRC_HCP = 0;
    localparam int SRC_PLC = 1;
    localparam int NUM_SRC = 2;

    typedef enum logic [1:0] {
        ING_IDLE    = 2'd0,
        ING_BODY    = 2'd1,
        ING_DISCARD = 2'd2
    } ing_state_t;

    typedef enum logic [1:0] {
        SCH_IDLE = 2'd0,
        SCH_SEND = 2'd1,
        SCH_GAP  = 2'd2
    } sch_state_t;

    // Returns a one-hot grant. When both sources are eligible the tie is
    // broken by prefer_plc (1 = PLC wins, 0 = HCP wins).
    function automatic logic [NUM_SRC-1:0] rr_pick(
        input logic [NUM_SRC-1:0] elig,
        input logic               prefer_plc
    );
        logic [NUM_SRC-1:0] pick;
        pick = '0;
        if (elig[SRC_HCP] && elig[SRC_PLC]) begin
            pick[prefer_plc ? SRC_PLC : SRC_HCP] = 1'b1;
        end else if (elig[SRC_HCP]) begin
            pick[SRC_HCP] = 1'b1;
        end else if (elig[SRC_PLC]) begin
            pick[SRC_PLC] = 1'b1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/tsmp_frame_fifo.sv
// Per-source frame FIFO with ingest FSM, committed-frame counter and drop
// pulse. Only whole frames become visible to the reader; a frame that runs
// out of space is rolled back and dropped.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   iv_data, i_data_wr : incoming byte stream (no backpressure)
//   i_rd             : pop the head word this cycle
//   i_frame_done     : the popped word is a frame tail; retire one frame
//   ov_head          : show-ahead head word
//   o_frame_avail    : at least one committed frame remains after this
//                      cycle's retire (if any)
//   o_drop           : one-cycle pulse, one frame dropped
module tsmp_frame_fifo
    import tsmp_pkg::*;
#(
    parameter int FIFO_AW = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] iv_data,
    input  logic                  i_data_wr,
    input  logic                  i_rd,
    input  logic                  i_frame_done,
    output logic [DATA_WIDTH-1:0] ov_head,
    output logic                  o_frame_avail,
    output logic                  o_drop
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = FIFO_AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ing_state_t    state_reg, state_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] frame_start_reg, frame_start_next;
    logic [PW-1:0] frame_cnt_reg;
    logic          drop_reg, drop_next;
    logic          mem_we;
    logic          commit;
    logic [PW-1:0] occupancy;
    logic          full;
    logic          flag;

    // Occupancy uses registered pointers only, so a pop frees space for
    // the writer one cycle later.
    assign occupancy = wr_ptr_reg - rd_ptr_reg;
    assign full      = (occupancy == PW'(DEPTH));
    assign flag      = iv_data[FLAG_BIT];

    always_comb begin
        state_next       = state_reg;
        wr_ptr_next      = wr_ptr_reg;
        frame_start_next = frame_start_reg;
        mem_we           = 1'b0;
        commit           = 1'b0;
        drop_next        = 1'b0;
        if (i_data_wr) begin
            case (state_reg)
                ING_IDLE: begin
                    // Bytes without the delimiter outside a frame are strays.
                    if (flag) begin
                        if (full) begin
                            drop_next  = 1'b1;
                            state_next = ING_DISCARD;
                        end else begin
                            mem_we           = 1'b1;
                            frame_start_next = wr_ptr_reg;
                            wr_ptr_next      = wr_ptr_reg + 1'b1;
                            state_next       = ING_BODY;
                        end
                    end
                end
                ING_BODY: begin
                    if (full) begin
                        // Roll back everything written for this frame.
                        drop_next   = 1'b1;
                        wr_ptr_next = frame_start_reg;
                        state_next  = flag ? ING_IDLE : ING_DISCARD;
                    end else begin
                        mem_we      = 1'b1;
                        wr_ptr_next = wr_ptr_reg + 1'b1;
                        if (flag) begin
                            commit     = 1'b1;
                            state_next = ING_IDLE;
                        end
                    end
                end
                ING_DISCARD: begin
                    if (flag) begin
                        state_next = ING_IDLE;
                    end
                end
                default: state_next = ING_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg       <= ING_IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            frame_start_reg <= '0;
            frame_cnt_reg   <= '0;
            drop_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wr_ptr_reg      <= wr_ptr_next;
            frame_start_reg <= frame_start_next;
            drop_reg        <= drop_next;
            if (i_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            // A commit and a retire in the same cycle cancel out.
            case ({commit, i_frame_done})
                2'b10:   frame_cnt_reg <= frame_cnt_reg + 1'b1;
                2'b01:   frame_cnt_reg <= frame_cnt_reg - 1'b1;
                default: frame_cnt_reg <= frame_cnt_reg;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define valid content.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[wr_ptr_reg[FIFO_AW-1:0]] <= iv_data;
        end
    end

    assign ov_head       = mem[rd_ptr_reg[FIFO_AW-1:0]];
    assign o_frame_avail = (frame_cnt_reg != '0) &&
                           !(i_frame_done && (frame_cnt_reg == PW'(1)));
    assign o_drop        = drop_reg;

endmodule

// File: rtl/tsmp_egress_arb.sv
// Merges HCP and PLC TSMP frames onto one egress byte stream. Each source
// has its own frame FIFO; a frame-level round-robin scheduler sends whole
// committed frames, never interleaved, with IFG idle cycles between them.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   iv_data_hcp/i_data_wr_hcp : HCP byte stream
//   iv_data_plc/i_data_wr_plc : PLC byte stream
//   ov_data, o_data_wr      : egress byte (0 when not valid)
//   o_drop_hcp, o_drop_plc  : one-cycle frame-drop pulses
//   ov_grant                : one-hot source being sent ([0]=HCP, [1]=PLC)
module tsmp_egress_arb
    import tsmp_pkg::*;
#(
    parameter int FIFO_AW = 8,
    parameter int IFG     = 2    // 0..256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] iv_data_hcp,
    input  logic                  i_data_wr_hcp,
    input  logic [DATA_WIDTH-1:0] iv_data_plc,
    input  logic                  i_data_wr_plc,
    output logic [DATA_WIDTH-1:0] ov_data,
    output logic                  o_data_wr,
    output logic                  o_drop_hcp,
    output logic                  o_drop_plc,
    output logic [1:0]            ov_grant
);

    // The GAP state's last cycle already arbitrates, so IFG GAP cycles
    // yield exactly IFG idle output cycles between frames.
    localparam logic [7:0] GAP_LAST = 8'((IFG > 0) ? IFG - 1 : 0);

    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
    logic [NUM_SRC-1:0]    src_wr;
    logic [DATA_WIDTH-1:0] src_head [NUM_SRC];
    logic [NUM_SRC-1:0]    src_avail;
    logic [NUM_SRC-1:0]    src_drop;
    logic [NUM_SRC-1:0]    src_rd;
    logic [NUM_SRC-1:0]    src_done;

    assign src_data[SRC_HCP] = iv_data_hcp;
    assign src_data[SRC_PLC] = iv_data_plc;
    assign src_wr[SRC_HCP]   = i_data_wr_hcp;
    assign src_wr[SRC_PLC]   = i_data_wr_plc;

    sch_state_t            state_reg, state_next;
    logic [NUM_SRC-1:0]    grant_reg, grant_next;
    logic                  first_reg, first_next;
    logic                  prio_plc_reg, prio_plc_next;
    logic [7:0]            gap_cnt_reg, gap_cnt_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  wr_reg, wr_next;
    logic                  pop;
    logic                  tail_pop;
    logic [NUM_SRC-1:0]    pick;
    logic [DATA_WIDTH-1:0] head_word;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_rd[gi]   = pop && grant_reg[gi];
            assign src_done[gi] = tail_pop && grant_reg[gi];

            tsmp_frame_fifo #(
                .FIFO_AW (FIFO_AW)
            ) u_fifo (
                .i_clk         (i_clk),
                .i_rst_n       (i_rst_n),
                .iv_data       (src_data[gi]),
                .i_data_wr     (src_wr[gi]),
                .i_rd          (src_rd[gi]),
                .i_frame_done  (src_done[gi]),
                .ov_head       (src_head[gi]),
                .o_frame_avail (src_avail[gi]),
                .o_drop        (src_drop[gi])
            );
        end
    endgenerate

    assign head_word = grant_reg[SRC_PLC] ? src_head[SRC_PLC] : src_head[SRC_HCP];
    // The head byte also carries the flag, so only a later flagged byte ends the frame.
    assign tail_pop  = (state_reg == SCH_SEND) && head_word[FLAG_BIT] && !first_reg;

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        first_next    = first_reg;
        prio_plc_next = prio_plc_reg;
        gap_cnt_next  = gap_cnt_reg;
        data_next     = '0;
        wr_next       = 1'b0;
        pop           = 1'b0;
        pick          = '0;
        case (state_reg)
            SCH_IDLE: begin
                pick       = rr_pick(src_avail, prio_plc_reg);
                grant_next = pick;
                if (pick != '0) begin
                    first_next = 1'b1;
                    state_next = SCH_SEND;
                end
            end
            SCH_SEND: begin
                pop        = 1'b1;
                wr_next    = 1'b1;
                data_next  = head_word;
                first_next = 1'b0;
                if (tail_pop) begin
                    prio_plc_next = grant_reg[SRC_HCP];
                    if (IFG == 0) begin
                        // Back-to-back: choose the next frame right away.
                        pick = rr_pick(src_avail, grant_reg[SRC_HCP]);
                        if (pick != '0) begin
                            grant_next = pick;
                            first_next = 1'b1;
                        end else begin
                            state_next = SCH_IDLE;
                        end
                    end else begin
                        gap_cnt_next = '0;
                        state_next   = SCH_GAP;
                    end
                end
            end
            SCH_GAP: begin
                // Grant is held for the first GAP cycle, which shows the tail byte.
                grant_next   = '0;
                gap_cnt_next = gap_cnt_reg + 1'b1;
                if (gap_cnt_reg == GAP_LAST) begin
                    pick = rr_pick(src_avail, prio_plc_reg);
                    if (pick != '0) begin
                        grant_next = pick;
                        first_next = 1'b1;
                        state_next = SCH_SEND;
                    end else begin
                        state_next = SCH_IDLE;
                    end
                end
            end
            default: begin
                grant_next = '0;
                state_next = SCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= SCH_IDLE;
            grant_reg    <= '0;
            first_reg    <= 1'b0;
            prio_plc_reg <= 1'b0;
            gap_cnt_reg  <= '0;
            data_reg     <= '0;
            wr_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            first_reg    <= first_next;
            prio_plc_reg <= prio_plc_next;
            gap_cnt_reg  <= gap_cnt_next;
            data_reg     <= data_next;
            wr_reg       <= wr_next;
        end
    end

    assign ov_data    = data_reg;
    assign o_data_wr  = wr_reg;
    assign ov_grant   = grant_reg;
    assign o_drop_hcp = src_drop[SRC_HCP];
    assign o_drop_plc = src_drop[SRC_PLC];

endmodule

// File: tb/tb_tsmp_egress_arb.sv
module tb_tsmp_egress_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] data_hcp, data_plc;
    logic       wr_hcp, wr_plc;
    logic [8:0] ov_data;
    logic       o_data_wr;
    logic       o_drop_hcp, o_drop_plc;
    logic [1:0] ov_grant;

    tsmp_egress_arb #(
        .FIFO_AW (3),
        .IFG     (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .iv_data_hcp   (data_hcp),
        .i_data_wr_hcp (wr_hcp),
        .iv_data_plc   (data_plc),
        .i_data_wr_plc (wr_plc),
        .ov_data       (ov_data),
        .o_data_wr     (o_data_wr),
        .o_drop_hcp    (o_drop_hcp),
        .o_drop_plc    (o_drop_plc),
        .ov_grant      (ov_grant)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [8:0] d;
        logic [1:0] g;
    } ev_t;

    ev_t        mon_q[$];
    ev_t        exp_q[$];
    int         drop_h_cyc[$];
    int         drop_p_cyc[$];
    logic [8:0] fr[$];
    logic [8:0] fr2[$];

    always @(negedge clk) begin
        if (o_data_wr) mon_q.push_back('{c: cyc, d: ov_data, g: ov_grant});
        if (o_drop_hcp) drop_h_cyc.push_back(cyc);
        if (o_drop_plc) drop_p_cyc.push_back(cyc);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One input cycle; c returns the cycle in which the byte is sampled.
    task automatic drive(input logic wh, input logic [8:0] dh,
                         input logic wp, input logic [8:0] dp, output int c);
        wr_hcp   = wh;
        data_hcp = wh ? dh : 9'h000;
        wr_plc   = wp;
        data_plc = wp ? dp : 9'h000;
        c        = cyc;
        @(posedge clk);
        #1;
        wr_hcp   = 1'b0;
        wr_plc   = 1'b0;
        data_hcp = 9'h000;
        data_plc = 9'h000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int src, output int tail_c);
        int c;
        c = 0;
        foreach (fr[i]) drive(src == 0, fr[i], src == 1, fr[i], c);
        tail_c = c;
    endtask

    task automatic add_frame(input int start_c, input logic [1:0] g);
        foreach (fr[i]) exp_q.push_back('{c: start_c + i, d: fr[i], g: g});
    endtask

    task automatic verify(input string tag);
        chk({tag, " count"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            $display("%s byte %0d: cyc %0d data %03h grant %b", tag, i,
                     mon_q[i].c, mon_q[i].d, mon_q[i].g);
            chk($sformatf("%s data[%0d]", tag, i), 32'(mon_q[i].d), 32'(exp_q[i].d));
            chk($sformatf("%s cyc[%0d]", tag, i), mon_q[i].c, exp_q[i].c);
            chk($sformatf("%s grant[%0d]", tag, i), 32'(mon_q[i].g), 32'(exp_q[i].g));
        end
        mon_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tc, tc2, c;
        tc = 0; tc2 = 0; c = 0;
        rst_n = 1'b0;
        wr_hcp = 1'b0; wr_plc = 1'b0;
        data_hcp = 9'h000; data_plc = 9'h000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset data", 32'(ov_data), 32'h0);
        chk("reset wr", 32'(o_data_wr), 32'h0);
        chk("reset grant", 32'(ov_grant), 32'h0);
        chk("reset drops", 32'({o_drop_hcp, o_drop_plc}), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: single HCP frame, first byte 3 cycles after tail
        fr = '{9'h1AA, 9'h011, 9'h022, 9'h1BB};
        send_frame(0, tc);
        add_frame(tc + 3, 2'b01);
        idle(12);
        verify("t1 hcp");
        @(negedge clk);
        chk("t1 idle grant", 32'(ov_grant), 32'h0);
        chk("t1 idle data", 32'(ov_data), 32'h0);
        idle(1);

        // T4: stray bytes on PLC before a valid frame
        drive(1'b0, 9'h000, 1'b1, 9'h055, c);
        drive(1'b0, 9'h000, 1'b1, 9'h066, c);
        fr = '{9'h1C0, 9'h0C1, 9'h1C2};
        send_frame(1, tc);
        add_frame(tc + 3, 2'b10);
        idle(12);
        verify("t4 stray");

        // T2: simultaneous commits twice, round-robin with IFG=2
        fr  = '{9'h1A1, 9'h0A2, 9'h1A3};
        fr2 = '{9'h1B1, 9'h0B2, 9'h1B3};
        for (int i = 0; i < 3; i++) drive(1'b1, fr[i], 1'b1, fr2[i], tc);
        add_frame(tc + 3, 2'b01);
        fr = fr2;
        add_frame(tc + 8, 2'b10);
        fr  = '{9'h1C1, 9'h0C2, 9'h1C3};
        fr2 = '{9'h1D1, 9'h0D2, 9'h1D3};
        for (int i = 0; i < 3; i++) drive(1'b1, fr[i], 1'b1, fr2[i], c);
        add_frame(tc + 13, 2'b01);
        fr = fr2;
        add_frame(tc + 18, 2'b10);
        idle(30);
        verify("t2 rr");

        // T3: 10-byte HCP frame overflows depth 8 and is dropped
        fr = '{9'h100, 9'h001, 9'h002, 9'h003, 9'h004,
               9'h005, 9'h006, 9'h007, 9'h008, 9'h109};
        send_frame(0, tc);
        idle(12);
        chk("t3 drop count", drop_h_cyc.size(), 1);
        if (drop_h_cyc.size() > 0) chk("t3 drop cyc", drop_h_cyc[0], tc);
        chk("t3 no output", mon_q.size(), 0);
        mon_q.delete();
        fr = '{9'h150, 9'h051, 9'h052, 9'h053, 9'h154};
        send_frame(0, tc2);
        add_frame(tc2 + 3, 2'b01);
        idle(14);
        verify("t3 after drop");

        // T5: PLC frame B commits on the cycle frame A's tail is popped
        fr = '{9'h1E0, 9'h0E1, 9'h0E2, 9'h1E3};
        send_frame(1, tc);
        add_frame(tc + 3, 2'b10);
        idle(2);
        fr = '{9'h1F0, 9'h0F1, 9'h1F2};
        send_frame(1, tc2);
        add_frame(tc + 9, 2'b10);
        idle(16);
        verify("t5 overlap");

        // T6: reset asserted while a frame is being sent
        fr = '{9'h1A0, 9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4, 9'h1A5};
        send_frame(0, tc);
        repeat (4) @(negedge clk);
        chk("t6 sending", 32'(o_data_wr), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6 rst wr", 32'(o_data_wr), 32'h0);
        chk("t6 rst data", 32'(ov_data), 32'h0);
        chk("t6 rst grant", 32'(ov_grant), 32'h0);
        mon_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t6 residual bytes", mon_q.size(), 0);
        chk("t6 grant idle", 32'(ov_grant), 32'h0);
        chk("plc drops", drop_p_cyc.size(), 0);
        chk("hcp drops total", drop_h_cyc.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
